// File: rtl/jtopl_eg_slot.sv
// jtopl_eg_slot: per-operator envelope state machine and 9-bit attenuation
// register. Picks the active ADSR rate for the step stage and applies the
// level update that the step stage requests once per sample.
// Level 0x000 is loudest, 0x1FF is silent.
module jtopl_eg_slot (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen_i,
    input  logic       keyon_i,
    input  logic [3:0] ar_i,
    input  logic [3:0] dr_i,
    input  logic [3:0] sl_i,
    input  logic [3:0] rr_i,
    input  logic       eg_type_i,
    input  logic       step_i,
    input  logic       sum_up_i,
    input  logic [5:0] rate_i,
    input  logic       cnt_lsb_i,
    output logic [4:0] base_rate_o,
    output logic       attack_o,
    output logic       cnt_in_o,
    output logic [8:0] eg_level_o,
    output logic [1:0] eg_state_o
);

    typedef enum logic [1:0] {
        ST_ATTACK  = 2'd0,
        ST_DECAY   = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } eg_state_t;

    eg_state_t  state_q, state_d;
    logic [8:0] level_q, level_d;
    logic       keyon_l_q;
    logic       cnt_q;

    logic [3:0] sel_rate;
    logic [3:0] inc;
    logic [9:0] level_sum;
    logic [8:0] level_up;
    logic [8:0] level_att;
    logic [4:0] sl_thr;
    logic       key_rise;
    logic       key_fall;
    logic       do_update;

    // Rate register handed to the step stage; held sustain asks for no steps
    always_comb begin
        sel_rate = rr_i;
        case (state_q)
            ST_ATTACK:  sel_rate = ar_i;
            ST_DECAY:   sel_rate = dr_i;
            ST_SUSTAIN: sel_rate = eg_type_i ? 4'd0 : rr_i;
            ST_RELEASE: sel_rate = rr_i;
            default:    sel_rate = rr_i;
        endcase
    end

    assign base_rate_o = {sel_rate, 1'b0};
    assign attack_o    = (state_q == ST_ATTACK);
    assign cnt_in_o    = cnt_q;
    assign eg_level_o  = level_q;
    assign eg_state_o  = state_q;

    // Increment size for the rising (attenuating) phases and its saturated sum
    always_comb begin
        if (rate_i[5:2] < 4'd12) begin
            inc = 4'd1;
        end else begin
            inc = 4'd1 << rate_i[3:2];
        end
        level_sum = {1'b0, level_q} + {6'd0, inc};
        level_up  = level_sum[9] ? 9'h1FF : level_sum[8:0];
        // level - level/8 - 1 only underflows when the level is already zero
        level_att = (level_q == 9'd0) ? 9'd0
                  : (level_q - {3'd0, level_q[8:3]} - 9'd1);
        sl_thr    = (sl_i == 4'hF) ? 5'h1F : {1'b0, sl_i};
    end

    assign key_rise  = keyon_i & ~keyon_l_q;
    assign key_fall  = ~keyon_i & keyon_l_q;
    assign do_update = step_i & sum_up_i;

    // Next state/level; key edges take priority over any level-driven change
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        if (key_rise) begin
            if (rate_i >= 6'd60) begin
                level_d = 9'd0;
                state_d = ST_DECAY;
            end else begin
                state_d = ST_ATTACK;
            end
        end else if (key_fall) begin
            state_d = ST_RELEASE;
        end else if (do_update) begin
            case (state_q)
                ST_ATTACK: begin
                    level_d = level_att;
                    if (level_att == 9'd0) begin
                        state_d = ST_DECAY;
                    end
                end
                ST_DECAY: begin
                    level_d = level_up;
                    if (level_up[8:4] >= sl_thr) begin
                        state_d = ST_SUSTAIN;
                    end
                end
                ST_SUSTAIN: begin
                    if (!eg_type_i) begin
                        level_d = level_up;
                    end
                end
                ST_RELEASE: begin
                    level_d = level_up;
                end
                default: begin
                    state_d = ST_RELEASE;
                end
            endcase
        end
    end

    // Sample-rate state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RELEASE;
            level_q   <= 9'h1FF;
            keyon_l_q <= 1'b0;
            cnt_q     <= 1'b0;
        end else if (cen_i) begin
            state_q   <= state_d;
            level_q   <= level_d;
            keyon_l_q <= keyon_i;
            cnt_q     <= cnt_lsb_i;
        end
    end

endmodule

// File: tb/tb_jtopl_eg_slot.sv
// Testbench for jtopl_eg_slot: table-driven vectors, directed envelope
// sequences and a randomized run against a behavioural envelope model.
module tb_jtopl_eg_slot;

    logic       clk;
    logic       rst_n;
    logic       cen;
    logic       keyon;
    logic [3:0] ar, dr, sl, rr;
    logic       eg_type;
    logic       step;
    logic       sum_up;
    logic [5:0] rate;
    logic       cnt_lsb;
    logic [4:0] base_rate;
    logic       attack;
    logic       cnt_in;
    logic [8:0] eg_level;
    logic [1:0] eg_state;

    int tests = 0;
    int fails = 0;

    jtopl_eg_slot dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cen_i      (cen),
        .keyon_i    (keyon),
        .ar_i       (ar),
        .dr_i       (dr),
        .sl_i       (sl),
        .rr_i       (rr),
        .eg_type_i  (eg_type),
        .step_i     (step),
        .sum_up_i   (sum_up),
        .rate_i     (rate),
        .cnt_lsb_i  (cnt_lsb),
        .base_rate_o(base_rate),
        .attack_o   (attack),
        .cnt_in_o   (cnt_in),
        .eg_level_o (eg_level),
        .eg_state_o (eg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock edge with the given inputs; outputs sampled 1 time unit later
    task automatic cyc(input logic c, input logic k, input logic s,
                       input logic u, input logic [5:0] r);
        cen = c; keyon = k; step = s; sum_up = u; rate = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        keyon = 1'b0; cen = 1'b0; step = 1'b0; sum_up = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Behavioural envelope model
    int  m_level, m_state, m_cnt;
    bit  m_kl;

    function automatic int m_inc(input int r);
        int e;
        e = r / 4;
        return (e < 12) ? 1 : (1 << (e - 12));
    endfunction

    function automatic int m_base(input int st);
        int r;
        case (st)
            0: r = ar;
            1: r = dr;
            2: r = eg_type ? 0 : rr;
            default: r = rr;
        endcase
        return r * 2;
    endfunction

    task automatic m_step();
        int thr;
        if (!cen) return;
        thr = (sl == 15) ? 31 : sl;
        if (keyon && !m_kl) begin
            if (rate >= 60) begin
                m_level = 0;
                m_state = 1;
            end else begin
                m_state = 0;
            end
        end else if (!keyon && m_kl) begin
            m_state = 3;
        end else if (step && sum_up) begin
            if (m_state == 0) begin
                m_level = m_level - m_level / 8 - 1;
                if (m_level <= 0) begin
                    m_level = 0;
                    m_state = 1;
                end
            end else if (m_state == 2 && eg_type) begin
                m_level = m_level;
            end else begin
                m_level = m_level + m_inc(rate);
                if (m_level > 511) m_level = 511;
                if (m_state == 1 && m_level / 16 >= thr) m_state = 2;
            end
        end
        m_kl  = keyon;
        m_cnt = cnt_lsb;
    endtask

    typedef struct {
        logic       cen, keyon, step, sum_up;
        logic [5:0] rate;
        logic       cnt_lsb;
        logic [8:0] exp_level;
        logic [1:0] exp_state;
        logic [4:0] exp_base;
        logic       exp_attack;
        logic       exp_cnt;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int  exp_l;
        bool_loop: begin end
        rst_n = 1'b1; cen = 0; keyon = 0; step = 0; sum_up = 0; rate = 0;
        cnt_lsb = 0; ar = 4'd10; dr = 4'd5; sl = 4'd4; rr = 4'd7; eg_type = 1'b1;

        // cen, keyon, step, sum_up, rate, cnt_lsb -> level, state, base, attack, cnt
        vecs[0]  = '{1, 1, 0, 0, 20, 1, 9'h1FF, 0, 20, 1, 1};
        vecs[1]  = '{1, 1, 1, 1, 20, 0, 9'h1BF, 0, 20, 1, 0};
        vecs[2]  = '{0, 1, 1, 1, 20, 1, 9'h1BF, 0, 20, 1, 0};
        vecs[3]  = '{1, 1, 1, 1, 20, 1, 9'h187, 0, 20, 1, 1};
        vecs[4]  = '{1, 1, 1, 0, 20, 0, 9'h187, 0, 20, 1, 0};
        vecs[5]  = '{1, 1, 0, 1, 20, 1, 9'h187, 0, 20, 1, 1};
        vecs[6]  = '{1, 0, 1, 1, 20, 0, 9'h187, 3, 14, 0, 0};
        vecs[7]  = '{1, 1, 1, 1, 20, 1, 9'h187, 0, 20, 1, 1};
        vecs[8]  = '{1, 0, 0, 0, 20, 0, 9'h187, 3, 14, 0, 0};
        vecs[9]  = '{1, 1, 0, 0, 63, 1, 9'h000, 1, 10, 0, 1};
        vecs[10] = '{1, 1, 1, 1, 20, 0, 9'h001, 1, 10, 0, 0};

        // Reset values, visible without any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_state", eg_state, 3);
        chk("reset_level", eg_level, 9'h1FF);
        chk("reset_cnt", cnt_in, 0);
        chk("reset_base", base_rate, 14);
        chk("reset_attack", attack, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        foreach (vecs[i]) begin
            cnt_lsb = vecs[i].cnt_lsb;
            cyc(vecs[i].cen, vecs[i].keyon, vecs[i].step, vecs[i].sum_up, vecs[i].rate);
            $display("[TB] vec %0d: level=%03h state=%0d base=%0d attack=%0b cnt=%0b",
                     i, eg_level, eg_state, base_rate, attack, cnt_in);
            chk($sformatf("vec%0d_level", i), eg_level, vecs[i].exp_level);
            chk($sformatf("vec%0d_state", i), eg_state, vecs[i].exp_state);
            chk($sformatf("vec%0d_base", i), base_rate, vecs[i].exp_base);
            chk($sformatf("vec%0d_attack", i), attack, vecs[i].exp_attack);
            chk($sformatf("vec%0d_cnt", i), cnt_in, vecs[i].exp_cnt);
        end

        // Full attack curve down to 0, then DECAY
        do_reset();
        cnt_lsb = 1'b0;
        cyc(1, 1, 0, 0, 20);
        chk("att_start_state", eg_state, 0);
        exp_l = 511;
        for (int i = 0; i < 80 && exp_l > 0; i++) begin
            cyc(1, 1, 1, 1, 20);
            exp_l = exp_l - exp_l / 8 - 1;
            if (exp_l < 0) exp_l = 0;
            chk("att_curve_level", eg_level, exp_l);
        end
        chk("att_reached_zero", exp_l, 0);
        chk("att_to_decay", eg_state, 1);
        $display("[TB] attack curve: level=%03h state=%0d", eg_level, eg_state);

        // Decay to sl=4 with inc 1, then held sustain
        sl = 4'd4; eg_type = 1'b1;
        for (int i = 0; i < 63; i++) cyc(1, 1, 1, 1, 20);
        chk("decay_3f_level", eg_level, 9'h03F);
        chk("decay_3f_state", eg_state, 1);
        cyc(1, 1, 1, 1, 20);
        chk("sus_level", eg_level, 9'h040);
        chk("sus_state", eg_state, 2);
        chk("sus_base", base_rate, 0);
        for (int i = 0; i < 1000; i++) cyc(1, 1, 1, 1, 20);
        chk("sus_hold_level", eg_level, 9'h040);
        chk("sus_hold_state", eg_state, 2);
        $display("[TB] held sustain: level=%03h state=%0d", eg_level, eg_state);

        // Percussive sustain, inc 8, saturation at 0x1FF
        eg_type = 1'b0;
        #1;
        chk("perc_base", base_rate, 14);
        for (int i = 0; i < 100 && eg_level != 9'h1F8; i++) cyc(1, 1, 1, 1, 60);
        chk("perc_1f8", eg_level, 9'h1F8);
        cyc(1, 1, 1, 1, 60);
        chk("perc_sat", eg_level, 9'h1FF);
        chk("perc_state", eg_state, 2);
        cyc(1, 1, 1, 1, 60);
        chk("perc_sat2", eg_level, 9'h1FF);
        cyc(1, 0, 0, 0, 60);
        chk("rel_state", eg_state, 3);
        cyc(1, 0, 1, 1, 60);
        chk("rel_sat", eg_level, 9'h1FF);
        $display("[TB] percussive/release: level=%03h state=%0d", eg_level, eg_state);

        // Keyoff mid-attack at 0x0C0 and retrigger from the current level
        do_reset();
        sl = 4'hF;
        cyc(1, 1, 0, 0, 63);
        for (int i = 0; i < 24; i++) cyc(1, 1, 1, 1, 60);
        chk("c0_level", eg_level, 9'h0C0);
        chk("c0_state", eg_state, 1);
        cyc(1, 0, 0, 0, 20);
        cyc(1, 1, 0, 0, 20);
        chk("c0_attack_state", eg_state, 0);
        cyc(1, 0, 1, 1, 20);
        chk("koff_state", eg_state, 3);
        chk("koff_base", base_rate, 14);
        chk("koff_level", eg_level, 9'h0C0);
        cyc(1, 1, 1, 1, 20);
        chk("retrig_state", eg_state, 0);
        chk("retrig_level", eg_level, 9'h0C0);
        chk("retrig_attack", attack, 1);
        $display("[TB] retrigger: level=%03h state=%0d", eg_level, eg_state);

        // Asynchronous reset mid-attack at 0x080
        do_reset();
        cnt_lsb = 1'b1;
        cyc(1, 1, 0, 0, 63);
        for (int i = 0; i < 16; i++) cyc(1, 1, 1, 1, 60);
        cyc(1, 0, 0, 0, 20);
        cyc(1, 1, 0, 0, 20);
        chk("pre_rst_level", eg_level, 9'h080);
        chk("pre_rst_state", eg_state, 0);
        chk("pre_rst_cnt", cnt_in, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", eg_state, 3);
        chk("async_rst_level", eg_level, 9'h1FF);
        chk("async_rst_cnt", cnt_in, 0);
        $display("[TB] async reset: level=%03h state=%0d", eg_level, eg_state);
        keyon = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized run against the model
        m_level = 511; m_state = 3; m_kl = 0; m_cnt = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) begin
                ar = 4'($urandom_range(0, 15));
                dr = 4'($urandom_range(0, 15));
                sl = 4'($urandom_range(0, 15));
                rr = 4'($urandom_range(0, 15));
                eg_type = 1'($urandom_range(0, 1));
            end
            cen     = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) keyon = ~keyon;
            step    = 1'($urandom_range(0, 1));
            sum_up  = 1'($urandom_range(0, 1));
            rate    = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(56, 63))
                                                  : 6'($urandom_range(0, 63));
            cnt_lsb = 1'($urandom_range(0, 1));
            m_step();
            @(posedge clk);
            #1;
            chk("rnd_level", eg_level, m_level);
            chk("rnd_state", eg_state, m_state);
            chk("rnd_cnt", cnt_in, m_cnt);
            chk("rnd_base", base_rate, m_base(m_state));
            chk("rnd_attack", attack, (m_state == 0) ? 1 : 0);
        end
        $display("[TB] random run: final level=%03h state=%0d", eg_level, eg_state);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
